// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD down-counter (99..00) used as the game/round timer.
// Counts down on CE ticks while running, supports load/start/pause,
// emits a one-cycle DONE pulse on expiry and exposes CE/CEO/TC cascade
// signals matching the up-counters elsewhere in the design.
module bcd_countdown_timer #(
    parameter bit         RELOAD     = 1'b0,
    parameter logic [7:0] INIT_VALUE = 8'h00
) (
    input  logic       C,
    input  logic       CLR,
    input  logic       CE,
    input  logic       LOAD,
    input  logic [3:0] D1,
    input  logic [3:0] D0,
    input  logic       START,
    input  logic       PAUSE,
    output logic [3:0] Q1,
    output logic [3:0] Q0,
    output logic       BUSY,
    output logic       DONE,
    output logic       TC,
    output logic       CEO
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        EXPIRE = 2'd3
    } state_t;

    // Saturate a raw nibble to a legal BCD digit.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // BCD decrement of a two-digit value; caller guarantees value > 01.
    function automatic logic [7:0] dec_bcd(input logic [3:0] t, input logic [3:0] o);
        if (o != 4'd0)
            return {t, o - 4'd1};
        else
            return {t - 4'd1, 4'd9};
    endfunction

    localparam logic [3:0] INIT_T = clamp_digit(INIT_VALUE[7:4]);
    localparam logic [3:0] INIT_O = clamp_digit(INIT_VALUE[3:0]);

    state_t     state, state_n;
    logic [3:0] q1_n, q0_n;
    logic [3:0] ld1, ld0, ld1_n, ld0_n;
    logic       done_n, busy_n;

    // State, digit, load-register and registered-output updates.
    always_ff @(posedge C or negedge CLR) begin
        if (!CLR) begin
            state <= IDLE;
            Q1    <= INIT_T;
            Q0    <= INIT_O;
            ld1   <= INIT_T;
            ld0   <= INIT_O;
            DONE  <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            state <= state_n;
            Q1    <= q1_n;
            Q0    <= q0_n;
            ld1   <= ld1_n;
            ld0   <= ld0_n;
            DONE  <= done_n;
            BUSY  <= busy_n;
        end
    end

    // Next-state logic; priority LOAD > PAUSE > START > CE decrement.
    always_comb begin
        state_n = state;
        q1_n    = Q1;
        q0_n    = Q0;
        ld1_n   = ld1;
        ld0_n   = ld0;
        done_n  = 1'b0;

        if (LOAD) begin
            q1_n    = clamp_digit(D1);
            q0_n    = clamp_digit(D0);
            ld1_n   = clamp_digit(D1);
            ld0_n   = clamp_digit(D0);
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!PAUSE && START)
                        state_n = ({Q1, Q0} == 8'h00) ? EXPIRE : RUN;
                end
                RUN: begin
                    if (PAUSE) begin
                        state_n = PAUSED;
                    end else if (CE) begin
                        // Reaching 00 (or already there) ends the count.
                        if ({Q1, Q0} <= 8'h01) begin
                            if (RELOAD) begin
                                q1_n   = ld1;
                                q0_n   = ld0;
                                done_n = 1'b1;
                            end else begin
                                q1_n    = 4'd0;
                                q0_n    = 4'd0;
                                state_n = EXPIRE;
                            end
                        end else begin
                            {q1_n, q0_n} = dec_bcd(Q1, Q0);
                        end
                    end
                end
                PAUSED: begin
                    if (!PAUSE && START)
                        state_n = RUN;
                end
                EXPIRE: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        if (state_n == EXPIRE)
            done_n = 1'b1;
        busy_n = (state_n == RUN) || (state_n == PAUSED);
    end

    // Cascade outputs: terminal count and borrow out.
    always_comb begin
        TC  = CLR && ({Q1, Q0} == 8'h00);
        CEO = CE && (state == RUN) && (Q0 == 4'd0);
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer: directed scenarios plus a
// randomized run compared against an integer-valued behavioural model.
module tb_bcd_countdown_timer;

    logic       C = 1'b0;
    logic       CLR = 1'b0;
    logic       CE = 1'b0, LOAD = 1'b0, START = 1'b0, PAUSE = 1'b0;
    logic [3:0] D1 = 4'd0, D0 = 4'd0;

    logic [3:0] q1a, q0a, q1b, q0b;
    logic       busya, donea, tca, ceoa;
    logic       busyb, doneb, tcb, ceob;

    int checks = 0;
    int errors = 0;

    bcd_countdown_timer #(.RELOAD(1'b0), .INIT_VALUE(8'h00)) dut0 (
        .C(C), .CLR(CLR), .CE(CE), .LOAD(LOAD), .D1(D1), .D0(D0),
        .START(START), .PAUSE(PAUSE), .Q1(q1a), .Q0(q0a),
        .BUSY(busya), .DONE(donea), .TC(tca), .CEO(ceoa));

    bcd_countdown_timer #(.RELOAD(1'b1), .INIT_VALUE(8'h00)) dut1 (
        .C(C), .CLR(CLR), .CE(CE), .LOAD(LOAD), .D1(D1), .D0(D0),
        .START(START), .PAUSE(PAUSE), .Q1(q1b), .Q0(q0b),
        .BUSY(busyb), .DONE(doneb), .TC(tcb), .CEO(ceob));

    always #5 C = ~C;

    // Behavioural model: value held as a plain integer 0..99.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;
    int mv[2], ml[2], ms[2];
    bit md[2];

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic drive(input logic ld, input logic [3:0] d1, input logic [3:0] d0,
                         input logic st, input logic ps, input logic ce);
        LOAD = ld; D1 = d1; D0 = d0; START = st; PAUSE = ps; CE = ce;
    endtask

    function automatic int min9(input int x);
        return (x > 9) ? 9 : x;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 2; r++) begin
            mv[r] = 0; ml[r] = 0; ms[r] = M_IDLE; md[r] = 0;
        end
    endtask

    task automatic model_edge();
        for (int r = 0; r < 2; r++) begin
            bit pulse;
            pulse = 0;
            if (LOAD) begin
                mv[r] = min9(int'(D1)) * 10 + min9(int'(D0));
                ml[r] = mv[r];
                ms[r] = M_IDLE;
            end else if (ms[r] == M_IDLE) begin
                if (!PAUSE && START) ms[r] = (mv[r] == 0) ? M_EXP : M_RUN;
            end else if (ms[r] == M_RUN) begin
                if (PAUSE) ms[r] = M_PAUSED;
                else if (CE) begin
                    if (mv[r] <= 1) begin
                        if (r == 1) begin mv[r] = ml[r]; pulse = 1; end
                        else begin mv[r] = 0; ms[r] = M_EXP; end
                    end else mv[r] = mv[r] - 1;
                end
            end else if (ms[r] == M_PAUSED) begin
                if (!PAUSE && START) ms[r] = M_RUN;
            end else begin
                ms[r] = M_IDLE;
            end
            md[r] = pulse || (ms[r] == M_EXP);
        end
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0);
        CLR = 1'b0;
        tick();
        checks++;
        if (q1a !== 4'd0 || q0a !== 4'd0 || busya !== 1'b0 || donea !== 1'b0 || tca !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got q=%h%h busy=%b done=%b tc=%b want q=00 busy=0 done=0 tc=0",
                     q1a, q0a, busya, donea, tca);
        end
        CLR = 1'b1;
        #1;
        checks++;
        if (tca !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_tc got %b want 1", tca);
        end
    endtask

    task automatic test_count();
        logic [7:0] exp_v [3];
        exp_v[0] = 8'h19; exp_v[1] = 8'h18; exp_v[2] = 8'h17;
        drive(1, 4'd2, 4'd0, 0, 0, 0);
        tick();
        checks++;
        if ({q1a, q0a} !== 8'h20 || busya !== 1'b0) begin
            errors++;
            $display("FAIL count_load got q=%h%h busy=%b want 20 busy=0", q1a, q0a, busya);
        end
        drive(0, 0, 0, 1, 0, 0);
        tick();
        checks++;
        if (busya !== 1'b1 || {q1a, q0a} !== 8'h20) begin
            errors++;
            $display("FAIL count_start got q=%h%h busy=%b want 20 busy=1", q1a, q0a, busya);
        end
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ceoa !== (i == 0)) begin
                errors++;
                $display("FAIL count_ceo step %0d got %b want %b", i, ceoa, (i == 0));
            end
            tick();
            checks++;
            if ({q1a, q0a} !== exp_v[i]) begin
                errors++;
                $display("FAIL count_dec step %0d got %h%h want %h", i, q1a, q0a, exp_v[i]);
            end
        end
        drive(1, 4'hC, 4'hC, 0, 0, 0);
        tick();
        checks++;
        if ({q1a, q0a} !== 8'h99) begin
            errors++;
            $display("FAIL count_clamp got %h%h want 99", q1a, q0a);
        end
    endtask

    task automatic test_expire();
        drive(1, 4'd0, 4'd2, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        tick();
        checks++;
        if ({q1a, q0a} !== 8'h01 || donea !== 1'b0) begin
            errors++;
            $display("FAIL expire_01 got q=%h%h done=%b want 01 done=0", q1a, q0a, donea);
        end
        tick();
        checks++;
        if ({q1a, q0a} !== 8'h00 || donea !== 1'b1 || busya !== 1'b0 || tca !== 1'b1) begin
            errors++;
            $display("FAIL expire_00 got q=%h%h done=%b busy=%b tc=%b want 00 done=1 busy=0 tc=1",
                     q1a, q0a, donea, busya, tca);
        end
        tick();
        checks++;
        if (donea !== 1'b0 || {q1a, q0a} !== 8'h00 || busya !== 1'b0) begin
            errors++;
            $display("FAIL expire_pulse_end got done=%b q=%h%h busy=%b want done=0 q=00 busy=0",
                     donea, q1a, q0a, busya);
        end
        tick();
        checks++;
        if (donea !== 1'b0 || {q1a, q0a} !== 8'h00) begin
            errors++;
            $display("FAIL expire_hold got done=%b q=%h%h want done=0 q=00", donea, q1a, q0a);
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_pause();
        drive(1, 4'd1, 4'd5, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        tick();
        checks++;
        if ({q1a, q0a} !== 8'h14) begin
            errors++;
            $display("FAIL pause_first got %h%h want 14", q1a, q0a);
        end
        drive(0, 0, 0, 0, 1, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        tick(); tick(); tick();
        checks++;
        if ({q1a, q0a} !== 8'h14 || busya !== 1'b1) begin
            errors++;
            $display("FAIL pause_hold got q=%h%h busy=%b want 14 busy=1", q1a, q0a, busya);
        end
        drive(0, 0, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        tick();
        checks++;
        if ({q1a, q0a} !== 8'h13) begin
            errors++;
            $display("FAIL pause_resume got %h%h want 13", q1a, q0a);
        end
        drive(0, 0, 0, 1, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        tick();
        checks++;
        if ({q1a, q0a} !== 8'h13 || busya !== 1'b1) begin
            errors++;
            $display("FAIL pause_and_start got q=%h%h busy=%b want 13 busy=1", q1a, q0a, busya);
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reload();
        logic [7:0] exp_v [3];
        exp_v[0] = 8'h02; exp_v[1] = 8'h01; exp_v[2] = 8'h03;
        drive(1, 4'd0, 4'd3, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({q1b, q0b} !== exp_v[i] || doneb !== (i == 2) || busyb !== 1'b1) begin
                errors++;
                $display("FAIL reload_step %0d got q=%h%h done=%b busy=%b want %h done=%b busy=1",
                         i, q1b, q0b, doneb, busyb, exp_v[i], (i == 2));
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (doneb !== 1'b0 || busyb !== 1'b1 || {q1b, q0b} !== 8'h03) begin
            errors++;
            $display("FAIL reload_after got q=%h%h done=%b busy=%b want 03 done=0 busy=1",
                     q1b, q0b, doneb, busyb);
        end
        drive(1, 4'd1, 4'd0, 0, 0, 1);
        tick();
        checks++;
        if ({q1b, q0b} !== 8'h10 || busyb !== 1'b0) begin
            errors++;
            $display("FAIL reload_load_run got q=%h%h busy=%b want 10 busy=0", q1b, q0b, busyb);
        end
        drive(0, 0, 0, 0, 0, 1);
        tick();
        checks++;
        if ({q1b, q0b} !== 8'h10) begin
            errors++;
            $display("FAIL reload_idle_hold got %h%h want 10", q1b, q0b);
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_zero_and_abort();
        drive(1, 4'd0, 4'd0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 0, 1);
        tick();
        checks++;
        if (donea !== 1'b1 || {q1a, q0a} !== 8'h00 || busya !== 1'b0) begin
            errors++;
            $display("FAIL zero_start got done=%b q=%h%h busy=%b want done=1 q=00 busy=0",
                     donea, q1a, q0a, busya);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (donea !== 1'b0) begin
            errors++;
            $display("FAIL zero_pulse_end got %b want 0", donea);
        end
        drive(1, 4'd4, 4'd3, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        tick();
        checks++;
        if ({q1a, q0a} !== 8'h42 || busya !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre got q=%h%h busy=%b want 42 busy=1", q1a, q0a, busya);
        end
        #2;
        CLR = 1'b0;
        #1;
        checks++;
        if ({q1a, q0a} !== 8'h00 || busya !== 1'b0 || donea !== 1'b0 || tca !== 1'b0) begin
            errors++;
            $display("FAIL abort_async got q=%h%h busy=%b done=%b tc=%b want 00 0 0 0",
                     q1a, q0a, busya, donea, tca);
        end
        tick();
        CLR = 1'b1;
        tick();
        checks++;
        if (donea !== 1'b0 || {q1a, q0a} !== 8'h00 || busya !== 1'b0) begin
            errors++;
            $display("FAIL abort_after got done=%b q=%h%h busy=%b want 0 00 0",
                     donea, q1a, q0a, busya);
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        drive(0, 0, 0, 0, 0, 0);
        CLR = 1'b0;
        #1;
        CLR = 1'b1;
        model_reset();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 15) == 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
            #1;
            checks++;
            if (ceoa !== (CE && ms[0] == M_RUN && (mv[0] % 10) == 0) ||
                ceob !== (CE && ms[1] == M_RUN && (mv[1] % 10) == 0)) begin
                errors++;
                $display("FAIL rand_ceo cycle %0d got %b/%b model values %0d/%0d", i, ceoa, ceob, mv[0], mv[1]);
            end
            model_edge();
            tick();
            checks++;
            if (q1a !== 4'(mv[0] / 10) || q0a !== 4'(mv[0] % 10) ||
                busya !== (ms[0] == M_RUN || ms[0] == M_PAUSED) || donea !== md[0] ||
                tca !== (mv[0] == 0)) begin
                errors++;
                $display("FAIL rand_norm cycle %0d got q=%h%h busy=%b done=%b tc=%b want %0d busy=%b done=%b",
                         i, q1a, q0a, busya, donea, tca, mv[0], (ms[0] == M_RUN || ms[0] == M_PAUSED), md[0]);
            end
            checks++;
            if (q1b !== 4'(mv[1] / 10) || q0b !== 4'(mv[1] % 10) ||
                busyb !== (ms[1] == M_RUN || ms[1] == M_PAUSED) || doneb !== md[1] ||
                tcb !== (mv[1] == 0)) begin
                errors++;
                $display("FAIL rand_reload cycle %0d got q=%h%h busy=%b done=%b tc=%b want %0d busy=%b done=%b",
                         i, q1b, q0b, busyb, doneb, tcb, mv[1], (ms[1] == M_RUN || ms[1] == M_PAUSED), md[1]);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_count();
        test_expire();
        test_pause();
        test_reload();
        test_zero_and_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Two-digit BCD down-counter timer (99..00) with load, start, pause and a done pulse.
- Counts down on qualified clock enables and mirrors the cascade signalling (CE/CEO/TC) of the up-counters in the same design.
- Used as the game or round timer. Its CE is driven by a 1 Hz tick chain; its digits drive the seven-segment decoder.

Parameters:
- RELOAD, 0: when 1, reaching 00 in RUN reloads the last loaded value and stays in RUN, instead of stopping.
- INIT_VALUE, 8'h00: BCD value restored by reset ({tens, ones}); each digit must be ≤ 9.

Ports:
- C  input  1  clock; all state updates on rising edge.
- CLR  input  1  asynchronous, active-low reset.
- CE  input  1  count enable (one-cycle tick); a decrement occurs only on edges where CE=1.
- LOAD  input  1  synchronous load of D1/D0.
- D1  input  4  tens digit to load (BCD).
- D0  input  4  ones digit to load (BCD).
- START  input  1  start or resume counting.
- PAUSE  input  1  suspend counting.
- Q1  output  4  current tens digit.
- Q0  output  4  current ones digit.
- BUSY  output  1  1 in RUN or PAUSED.
- DONE  output  1  registered one-cycle pulse when the count expires.
- TC  output  1  terminal count: {Q1,Q0}==00; forced 0 while CLR low.
- CEO  output  1  borrow out: CE & (state==RUN) & (Q0==0).

Behaviour:
- Reset (CLR=0, async):
  - Q1/Q0 = INIT_VALUE; load register = INIT_VALUE.
  - state = IDLE; DONE=0; BUSY=0; TC=0.
  - Reset mid-RUN aborts the count immediately; no DONE pulse is issued.
- States: IDLE, RUN, PAUSED, EXPIRE.
  - EXPIRE lasts exactly one cycle; DONE=1 only while in EXPIRE.
- Priority per edge: LOAD > PAUSE > START > CE decrement.
- LOAD (any state):
  - Q1←min(D1,9), Q0←min(D0,9); the load register captures the same clamped values.
  - state→IDLE; any pending decrement on that edge is dropped.
- IDLE:
  - START with value ≠ 00 → RUN.
  - START with value = 00 → EXPIRE.
- RUN:
  - CE=1, value ≠ 01: BCD decrement. If Q0>0, Q0←Q0-1; else Q0←9 and Q1←Q1-1.
  - CE=1, value = 01: Q←00 and state→EXPIRE.
    - If RELOAD=1, Q←load register instead, state stays RUN, and DONE still pulses one cycle (DONE asserted from the RUN path; EXPIRE is not entered).
  - PAUSE → PAUSED; the value is held and the CE on that edge is ignored.
- PAUSED:
  - START → RUN; CE is ignored while paused.
  - PAUSE and START together → remain PAUSED.
- EXPIRE → IDLE on the next edge. Q remains 00 until the next LOAD.
- START while already in RUN: no effect.
- Latency:
  - START→RUN: 1 edge.
  - The first decrement can occur on the edge after entering RUN.
  - DONE is asserted in the cycle after the edge that produced 00.
- Outputs Q1/Q0/BUSY/DONE are registered; TC and CEO are combinational from state/Q/CE/CLR.
- Digit values never exceed 9 under any input sequence.

Test Plan:
1. Reset: CLR=0 mid-count with INIT_VALUE=00 → Q1=0, Q0=0, BUSY=0, DONE=0, TC=0; release CLR → TC=1.
2. Load D1=2, D0=0, START, then 3 CE pulses → values 20→19→18→17. CEO=1 only in the cycle when Q0=0 and CE=1. Invalid D1=D0=4'hC loads as 99.
3. Load 02, START, CE,CE → 01→00; DONE high for exactly one cycle; state returns to IDLE (BUSY=0); further CE leaves 00.
4. Load 15, START, CE → 14; PAUSE with CE → holds 14; CE ×3 in PAUSED → still 14; START → RUN; CE → 13. PAUSE and START together in RUN → PAUSED.
5. RELOAD=1: load 03, START, 3 CE → 02,01,03 with one DONE pulse; BUSY stays 1. LOAD of 10 during RUN → Q=10, IDLE, no decrement that edge.
6. START with value 00 → one-cycle DONE, no decrement. Assert CLR low during RUN at value 42 → immediate reset, no DONE.
